// File: rtl/cardinal_nic.sv
// Cardinal ring NIC: processor-visible register file bridging one router port.
// Define CARDINAL_NIC_OUT_FIFO2_EN to use a 2-entry output FIFO instead of a single slot.
module cardinal_nic (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:1]  addr,
    input  logic [0:63] d_in,
    output logic [0:63] d_out,
    input  logic        nicEn,
    input  logic        nicWrEn,
    input  logic        net_si,
    output logic        net_ri,
    input  logic [0:63] net_di,
    output logic        net_so,
    input  logic        net_ro,
    output logic [0:63] net_do
);

    typedef enum logic [1:0] {
        REG_IN_BUF     = 2'b00,
        REG_IN_STATUS  = 2'b01,
        REG_OUT_BUF    = 2'b10,
        REG_OUT_STATUS = 2'b11
    } nic_reg_e;

    logic        in_full;
    logic [0:63] in_data;
    logic        out_full;
    logic        proc_rd;
    logic        proc_wr;
    logic        in_accept;
    logic        in_clear;
    logic        out_push;
    logic        out_pop;

    assign proc_rd   = nicEn & ~nicWrEn;
    assign proc_wr   = nicEn & nicWrEn;
    assign net_ri    = ~in_full;
    assign in_accept = net_si & ~in_full;
    assign in_clear  = proc_rd && (nic_reg_e'(addr) == REG_IN_BUF) && in_full;

    // Input side: a single slot; arrival and read-clear are mutually exclusive
    // because net_ri is low whenever the slot is full.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_full <= 1'b0;
            in_data <= '0;
        end else if (in_accept) begin
            in_full <= 1'b1;
            in_data <= net_di;
        end else if (in_clear) begin
            in_full <= 1'b0;
        end
    end

`ifdef CARDINAL_NIC_OUT_FIFO2_EN
    logic [0:63] out_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    assign out_full = (count == 2'd2);
    assign net_so   = (count != 2'd0);
    assign net_do   = net_so ? out_mem[rd_ptr] : '0;
    // Fullness is judged before the pop, so a push into a full FIFO is dropped
    // even when the router drains an entry in the same cycle.
    assign out_push = proc_wr && (nic_reg_e'(addr) == REG_OUT_BUF) && !out_full;
    assign out_pop  = net_so & net_ro;

    // NOTE: the storage entries are reset too, so net_do and reads are defined from reset onward.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) out_mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (out_push) begin
                out_mem[wr_ptr] <= d_in;
                wr_ptr          <= ~wr_ptr;
            end
            if (out_pop) rd_ptr <= ~rd_ptr;
            case ({out_push, out_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
`else
    logic [0:63] out_data;

    assign net_so   = out_full;
    assign net_do   = out_full ? out_data : '0;
    assign out_push = proc_wr && (nic_reg_e'(addr) == REG_OUT_BUF) && !out_full;
    assign out_pop  = out_full & net_ro;

    // NOTE: the storage entry is reset too, so net_do and reads are defined from reset onward.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_full <= 1'b0;
            out_data <= '0;
        end else if (out_push) begin
            out_full <= 1'b1;
            out_data <= d_in;
        end else if (out_pop) begin
            out_full <= 1'b0;
        end
    end
`endif

    // NOTE: d_out gets a default before the case so no latch is inferred.
    always_comb begin
        d_out = '0;
        if (proc_rd) begin
            case (nic_reg_e'(addr))
                REG_IN_BUF:     d_out = in_data;
                REG_IN_STATUS:  d_out = {63'b0, in_full};
                REG_OUT_STATUS: d_out = {63'b0, out_full};
                default:        d_out = '0;
            endcase
        end
    end

endmodule

// File: doc/cardinal_nic.md
# cardinal_nic

Network interface controller between the processor wrapper's NIC port and one Cardinal ring router port. The processor sees four 64-bit registers through a 2-bit address: input channel buffer, input status, output channel buffer and output status. On the router side the block moves whole 64-bit packets with a send/ready handshake. Each direction has its own buffer, so the processor can poll for packets and inject them without stalling the pipeline.

## Interface
- Parameters: none; widths fixed, bit 0 is MSB on all buses.
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; asserting it clears all state immediately
- addr  input  2  register select from processor (00 in-buf, 01 in-status, 10 out-buf, 11 out-status)
- d_in  input  64  write data from processor
- d_out  output  64  read data to processor
- nicEn  input  1  processor access enable
- nicWrEn  input  1  1 = write, 0 = read (qualified by nicEn)
- net_si  input  1  router has a packet for the NIC
- net_ri  output  1  NIC can accept a packet from the router
- net_di  input  64  packet from router
- net_so  output  1  NIC has a packet for the router
- net_ro  input  1  router can accept a packet from the NIC
- net_do  output  64  packet to router

## Operation
- Input buffer: one 64-bit entry plus in_full flag.
  - net_ri = ~in_full.
  - On net_si & net_ri: latch net_di and set in_full.
- Output buffer: one entry plus out_full flag by default (see Configuration).
  - net_so = out non-empty.
  - net_do = head entry; 0 when empty.
- Processor reads (nicEn=1, nicWrEn=0). d_out is combinational from addr.
  - 00: input buffer data. If in_full=1, clear in_full at the edge.
  - 01: {63'b0, in_full}.
  - 11: {63'b0, out_full}.
  - 10: 64'b0.
- Processor writes (nicEn=1, nicWrEn=1).
  - 10: push d_in into the output buffer if it is not full; a write when full is silently dropped.
  - Writes to 00, 01 and 11 are ignored.
- d_out is 64'b0 whenever nicEn=0 or nicWrEn=1.
- Read of 00 with in_full=0 returns stale buffer contents and has no side effect.
- Router send: on net_so & net_ro, pop the head at the edge.
- Simultaneous events:
  - Pop and push in the same cycle: "full" is evaluated before the pop. A push with full=1 is dropped even if a pop occurs that cycle.
  - Input read-clear and router arrival cannot coincide, because net_ri=0 while full.
- Reset values:
  - in_full=0 and out_full=0; all buffer entries 0.
  - net_ri=1, net_so=0, net_do=0, d_out=0.
- Reset asserted mid-transfer discards any buffered packets. The first handshake after reset release is accepted normally.

## Timing
- Router to NIC: packet accepted at edge N. in_full=1 is readable at 01 in cycle N+1, and net_ri=0 from N+1.
- Processor read-clear of 00 at edge N: net_ri=1 from cycle N+1. The next router packet can be accepted at edge N+1.
- Processor write to 10 at edge N: net_so=1 and net_do valid from cycle N+1, so the earliest pop is edge N+1.
- Throughput is one packet per 2 cycles per direction with depth 1.
- No combinational path from net_si to net_ri, or from net_ro to net_so.

## Configuration
- CARDINAL_NIC_OUT_FIFO2_EN
  - Defined: output buffer is a 2-entry FIFO with a 2-bit count. out_full (status 11) = count==2, and net_so = count!=0. Push with count 1 and a simultaneous pop keeps count at 1 and preserves order.
  - Undefined: single-entry output buffer as above; status 11 bit 63 = out_full.
- The input side is unaffected by the macro.

## Test plan
- Reset with reset=0 mid-operation: all outputs at reset values immediately; net_ri=1, net_so=0, d_out=0, status reads 0.
- Router delivers 64'hDEAD_BEEF_0000_0001: status 01 reads 1 and net_ri=0. Read 00 returns the packet, then status reads 0 and net_ri=1 next cycle.
- Write 64'h0123_4567_89AB_CDEF to 10 with net_ro=0: net_so=1 and net_do holds the value.
  - Second write 64'h1 (depth 1) is dropped.
  - Raise net_ro: one-cycle pop, then net_so=0 and status 11 reads 0.
- Back-to-back: write 10 and pop in the same cycle with out_full=1. The new data is dropped and net_so=0 the next cycle.
- With CARDINAL_NIC_OUT_FIFO2_EN: write A then B, and status 11 reads 1. A third write C is dropped. With net_ro=1, the router receives A then B in order.
